// File: rtl/cond_exec_stage_if.sv
// cond_exec_stage_if
//   Bundles the decode-to-execute control bus of cond_exec_stage.
//   master : hazard/decode side. It drives Stall, Flush, the D-stage controls
//            and ALUFlags, and it observes the E-stage outputs.
//   slave  : cond_exec_stage.
//   Signals: Stall, Flush, RegWD, MemWD, MemToRegD, ALUSrcD, PCSD,
//            FlagWD[1:0], ALUControlD[3:0], CondD[3:0], ALUFlags[3:0] ->
//            RegWE, MemWE, PCSrcE, MemToRegE, ALUSrcE, ALUControlE[3:0],
//            CondExE, FlagsE[3:0]
//            SquashCnt[CNT_W-1:0] exists only when COND_SQUASH_CNT_EN is defined.
interface cond_exec_stage_if #(
    parameter int CNT_W = 16
) ();
    logic       Stall;
    logic       Flush;
    logic       RegWD;
    logic       MemWD;
    logic       MemToRegD;
    logic       ALUSrcD;
    logic       PCSD;
    logic [1:0] FlagWD;
    logic [3:0] ALUControlD;
    logic [3:0] CondD;
    logic [3:0] ALUFlags;

    logic       RegWE;
    logic       MemWE;
    logic       PCSrcE;
    logic       MemToRegE;
    logic       ALUSrcE;
    logic [3:0] ALUControlE;
    logic       CondExE;
    logic [3:0] FlagsE;
`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] SquashCnt;
`else
    // CNT_W only sizes the optional counter.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    modport master (
        output Stall, Flush, RegWD, MemWD, MemToRegD, ALUSrcD, PCSD,
               FlagWD, ALUControlD, CondD, ALUFlags,
        input  RegWE, MemWE, PCSrcE, MemToRegE, ALUSrcE, ALUControlE,
               CondExE, FlagsE
`ifdef COND_SQUASH_CNT_EN
        , input SquashCnt
`endif
    );

    modport slave (
        input  Stall, Flush, RegWD, MemWD, MemToRegD, ALUSrcD, PCSD,
               FlagWD, ALUControlD, CondD, ALUFlags,
        output RegWE, MemWE, PCSrcE, MemToRegE, ALUSrcE, ALUControlE,
               CondExE, FlagsE
`ifdef COND_SQUASH_CNT_EN
        , output SquashCnt
`endif
    );
endinterface

// File: rtl/cond_exec_stage.sv
// cond_exec_stage
//   ARM-style execute-stage pipeline register with conditional execution.
//   It latches the decode controls into E, evaluates the condition field
//   against the NZCV flag register, gates the write and branch strobes, and
//   updates the flags when a passing instruction requests it.
//   Ports: CLK  - clock. All state changes on the rising edge.
//          RST  - synchronous, active-high reset.
//          bus  - cond_exec_stage_if.slave, which carries the controls, the
//                 flags and the E outputs.
//   Optional: define COND_SQUASH_CNT_EN to add SquashCnt, a saturating count
//             of valid instructions whose condition failed.
module cond_exec_stage #(
    parameter int CNT_W = 16
) (
    input logic            CLK,
    input logic            RST,
    cond_exec_stage_if.slave bus
);
    logic       rege, meme, memtorege, alusrce, pcse, valide;
    logic [1:0] flagwe;
    logic [3:0] alucontrole, conde;
    logic [3:0] flags;
    logic       condex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    // A bubble is loaded with CondE = AL, so CondExE reads 1 while the stage is empty.
    always_ff @(posedge CLK) begin
        if (RST || bus.Flush) begin
            rege        <= 1'b0;
            meme        <= 1'b0;
            memtorege   <= 1'b0;
            alusrce     <= 1'b0;
            pcse        <= 1'b0;
            flagwe      <= '0;
            alucontrole <= '0;
            conde       <= 4'b1110;
            valide      <= 1'b0;
        end else if (!bus.Stall) begin
            rege        <= bus.RegWD;
            meme        <= bus.MemWD;
            memtorege   <= bus.MemToRegD;
            alusrce     <= bus.ALUSrcD;
            pcse        <= bus.PCSD;
            flagwe      <= bus.FlagWD;
            alucontrole <= bus.ALUControlD;
            conde       <= bus.CondD;
            valide      <= 1'b1;
        end
    end

    always_comb begin
        condex = 1'b0;
        unique case (conde)
            4'b0000: condex = z;
            4'b0001: condex = !z;
            4'b0010: condex = c;
            4'b0011: condex = !c;
            4'b0100: condex = n;
            4'b0101: condex = !n;
            4'b0110: condex = v;
            4'b0111: condex = !v;
            4'b1000: condex = c & !z;
            4'b1001: condex = !c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = !z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // The flags are written by the instruction currently in E. Flush does not
    // cancel that write, because only the incoming instruction is bubbled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flags <= '0;
        end else if (!bus.Stall) begin
            if (flagwe[1] && condex) flags[3:2] <= bus.ALUFlags[3:2];
            if (flagwe[0] && condex) flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

    assign bus.RegWE       = rege & condex;
    assign bus.MemWE       = meme & condex;
    assign bus.PCSrcE      = pcse & condex;
    assign bus.MemToRegE   = memtorege;
    assign bus.ALUSrcE     = alusrce;
    assign bus.ALUControlE = alucontrole;
    assign bus.CondExE     = condex;
    assign bus.FlagsE      = flags;

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squashcnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            squashcnt <= '0;
        end else if (valide && !condex && !bus.Stall && squashcnt != '1) begin
            squashcnt <= squashcnt + 1'b1;
        end
    end

    assign bus.SquashCnt = squashcnt;
`else
    // valide and CNT_W are only consumed by the optional counter.
    logic unused_valide;
    assign unused_valide = valide;
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif
endmodule

// File: doc/cond_exec_stage.md
COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the squash counter.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports Stall and Flush  input  1 each  hold and bubble requests from the hazard logic.
REQ-005 SHALL have ports RegWD, MemWD, MemToRegD, ALUSrcD and PCSD  input  1 each  decode-stage control bits.
REQ-006 SHALL have port FlagWD  input  2  flag-write enables: bit1 updates N and Z; bit0 updates C and V.
REQ-007 SHALL have ports ALUControlD and CondD  input  4 each  decode-stage ALU operation and condition field (Instr[31:28]).
REQ-008 SHALL have port ALUFlags  input  4  {N,Z,C,V} from the execute-stage ALU, combinational in the current cycle.
REQ-009 SHALL have ports RegWE, MemWE and PCSrcE  output  1 each  condition-gated execute-stage write and branch strobes.
REQ-010 SHALL have ports MemToRegE and ALUSrcE  output  1 each, and ALUControlE  output  4  registered, ungated controls.
REQ-011 SHALL have ports CondExE  output  1  condition passed, and FlagsE  output  4  current {N,Z,C,V} register.

Function
REQ-012 SHALL load all D inputs into the E register and set internal ValidE on a rising edge with RST=0, Flush=0 and Stall=0.
REQ-013 SHALL, on Flush=1, load a bubble: all 1-bit controls 0, FlagWE=00, ALUControlE=0000, CondE=1110, ValidE=0; Flush has priority over Stall.
REQ-014 SHALL hold the E register unchanged on Stall=1 with Flush=0.
REQ-015 SHALL compute CondExE combinationally from CondE and FlagsE with ARM encoding: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 fails (0).
REQ-016 SHALL drive RegWE, MemWE and PCSrcE as the registered bits ANDed with CondExE; zero latency from the E register.
REQ-017 SHALL update N,Z from ALUFlags[3:2] when FlagWE[1]&CondExE, and C,V from ALUFlags[1:0] when FlagWE[0]&CondExE, at the rising edge.
REQ-018 SHALL suppress the flag update while Stall=1, so a held instruction is evaluated against stable flags.
REQ-019 SHALL let the instruction entering E on the same edge as a flag update see the updated flags in its own cycle (no extra latency).
REQ-020 SHALL treat a flag-setting instruction whose condition fails as writing no flags.

Reset
REQ-021 SHALL, on RST=1 at a rising edge, apply the bubble of REQ-013 and clear FlagsE to 0000, overriding Stall and Flush.
REQ-022 SHALL, after reset, output RegWE=MemWE=PCSrcE=MemToRegE=ALUSrcE=0, ALUControlE=0000, CondExE=1, FlagsE=0000.
REQ-023 SHALL, on reset mid-operation, discard the in-flight instruction with no flag or strobe side effects in that cycle.

Configuration
REQ-024 SHALL, with macro COND_SQUASH_CNT_EN defined, add output SquashCnt, width CNT_W, reset to 0.
REQ-025 SQUASHCNT SHALL increment by one on each edge with ValidE=1, CondExE=0 and Stall=0, and SHALL saturate at all-ones.
REQ-026 SHALL, with COND_SQUASH_CNT_EN undefined, omit the SquashCnt port and counter logic, and all other behaviour SHALL be identical.

Verification
REQ-027 SHALL cover: after reset, load CondD=0000 with RegWD=1 and flags 0000 -> RegWE=0, CondExE=0.
REQ-028 SHALL cover: flag-setting instruction, FlagWD=11, CondD=1110, ALUFlags=0100, then a second instruction with CondD=0000 and MemWD=1 -> FlagsE=0100 and MemWE=1 in the second instruction's cycle.
REQ-029 SHALL cover: CondD=1011 with FlagWD=11 and FlagsE=1000 (LT true) -> CondExE=1, and ALUFlags=0000 is written on the edge.
REQ-030 SHALL cover: the same instruction with FlagsE=1001 (LT false) -> FlagsE stays 1001.
REQ-031 SHALL cover: Stall=1 for 3 cycles with PCSD=1 and CondD=1110 -> PCSrcE=1 held, FlagsE unchanged; then Flush=1 with Stall=1 -> bubble loaded, PCSrcE=0.
REQ-032 SHALL cover, with COND_SQUASH_CNT_EN: 5 consecutive valid CondD=1111 instructions then 2 bubbles -> SquashCnt=5; with CNT_W=2, the same sequence -> SquashCnt=3 (saturated).
